// File: rtl/pool_ctrl_if.sv
// Handshake and bus bundle between the pooling controller and its
// surroundings: sample stream in, pooling datapath control, result buffer out.
interface pool_ctrl_if #(
  parameter int DW = 16
);
  // frame control
  logic          start;
  logic          abort;
  // sample stream from the convolution stage
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  // pooling datapath
  logic          pool_en_reg;
  logic [DW-1:0] pool_din;
  logic          pool_en;
  logic [DW-1:0] pool_out;
  logic [15:0]   pool_addr;
  logic          pool_done;
  logic          pool_rst_n;
  // result buffer
  logic          wr_en;
  logic [15:0]   wr_addr;
  logic [DW-1:0] wr_data;
  // status
  logic          busy;
  logic          frame_done;
  logic          err;

  // environment side: drives requests, samples and datapath responses
  modport master (
    output start, abort, in_valid, in_data, pool_out, pool_addr, pool_done,
    input  in_ready, pool_en_reg, pool_din, pool_en, pool_rst_n,
    input  wr_en, wr_addr, wr_data, busy, frame_done, err
  );

  // controller side
  modport slave (
    input  start, abort, in_valid, in_data, pool_out, pool_addr, pool_done,
    output in_ready, pool_en_reg, pool_din, pool_en, pool_rst_n,
    output wr_en, wr_addr, wr_data, busy, frame_done, err
  );
endinterface

// File: rtl/pool_ctrl.sv
// Pooling frame controller: loads a 2N x 2N tile of samples into the pooling
// datapath, collects the N x N pooled results into a result buffer, waits for
// the datapath to finish (with timeout), clears it and signals completion.
module pool_ctrl #(
  parameter int N   = 3,
  parameter int DW  = 16,
  parameter int TMO = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  pool_ctrl_if.slave bus
);

  localparam int NSMP = 4 * N * N;
  localparam int NWR  = N * N;
  localparam int SCW  = $clog2(NSMP + 1);
  localparam int WCW  = $clog2(NWR + 1);
  localparam int TCW  = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    POOL,
    WAIT,
    CLEAR,
    DONE
  } state_t;

  // Per-state registered control outputs, loaded together with the state.
  typedef struct packed {
    logic in_ready;
    logic pool_en;
    logic pool_rst_n;
    logic busy;
    logic frame_done;
  } flags_t;

  function automatic flags_t flags_for(state_t s);
    flags_t f;
    f = '{in_ready: 1'b0, pool_en: 1'b0, pool_rst_n: 1'b1, busy: 1'b1, frame_done: 1'b0};
    case (s)
      IDLE:    f.busy       = 1'b0;
      LOAD:    f.in_ready   = 1'b1;
      POOL:    f.pool_en    = 1'b1;
      WAIT:    f.pool_en    = 1'b1;
      CLEAR:   f.pool_rst_n = 1'b0;
      DONE:    f.frame_done = 1'b1;
      default: f.busy       = 1'b0;
    endcase
    return f;
  endfunction

  state_t           state_reg;
  flags_t           flags_reg;
  logic [SCW-1:0]   smp_cnt_reg;
  logic [WCW-1:0]   wr_cnt_reg;
  logic [TCW-1:0]   tmo_cnt_reg;
  logic             aborted_reg;
  logic             err_reg;
  logic             wr_en_reg;
  logic [15:0]      wr_addr_reg;
  logic [DW-1:0]    wr_data_reg;
  logic             accept;

  // A sample is taken only while loading and never in an abort cycle.
  assign accept = flags_reg.in_ready & bus.in_valid & ~bus.abort;

  // Frame sequencing, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      flags_reg   <= '0;
      smp_cnt_reg <= '0;
      wr_cnt_reg  <= '0;
      tmo_cnt_reg <= '0;
      aborted_reg <= 1'b0;
      err_reg     <= 1'b0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      // Refresh outputs of the current state; transitions below override.
      flags_reg <= flags_for(state_reg);
      wr_en_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg   <= LOAD;
            flags_reg   <= flags_for(LOAD);
            smp_cnt_reg <= '0;
            wr_cnt_reg  <= '0;
            aborted_reg <= 1'b0;
          end
        end
        LOAD: begin
          if (bus.abort) begin
            state_reg   <= CLEAR;
            flags_reg   <= flags_for(CLEAR);
            aborted_reg <= 1'b1;
          end else if (accept) begin
            smp_cnt_reg <= smp_cnt_reg + 1'b1;
            if (smp_cnt_reg == SCW'(NSMP - 1)) begin
              state_reg <= POOL;
              flags_reg <= flags_for(POOL);
            end
          end
        end
        POOL: begin
          if (bus.abort) begin
            state_reg   <= CLEAR;
            flags_reg   <= flags_for(CLEAR);
            aborted_reg <= 1'b1;
          end else begin
            wr_en_reg   <= 1'b1;
            wr_addr_reg <= bus.pool_addr;
            wr_data_reg <= bus.pool_out;
            wr_cnt_reg  <= wr_cnt_reg + 1'b1;
            if (wr_cnt_reg == WCW'(NWR - 1)) begin
              state_reg   <= WAIT;
              flags_reg   <= flags_for(WAIT);
              tmo_cnt_reg <= '0;
            end
          end
        end
        WAIT: begin
          if (bus.abort) begin
            state_reg   <= CLEAR;
            flags_reg   <= flags_for(CLEAR);
            aborted_reg <= 1'b1;
          end else if (bus.pool_done) begin
            state_reg <= CLEAR;
            flags_reg <= flags_for(CLEAR);
          end else if (tmo_cnt_reg == TCW'(TMO - 1)) begin
            err_reg   <= 1'b1;
            state_reg <= CLEAR;
            flags_reg <= flags_for(CLEAR);
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        CLEAR: begin
          // Aborted frames skip the completion pulse.
          state_reg   <= aborted_reg ? IDLE : DONE;
          flags_reg   <= flags_for(aborted_reg ? IDLE : DONE);
          aborted_reg <= 1'b0;
        end
        DONE: begin
          state_reg <= IDLE;
          flags_reg <= flags_for(IDLE);
        end
        default: begin
          state_reg <= IDLE;
          flags_reg <= flags_for(IDLE);
        end
      endcase
    end
  end

  assign bus.in_ready    = flags_reg.in_ready;
  assign bus.pool_en_reg = accept;
  assign bus.pool_din    = bus.in_data;
  assign bus.pool_en     = flags_reg.pool_en;
  assign bus.pool_rst_n  = flags_reg.pool_rst_n;
  assign bus.busy        = flags_reg.busy;
  assign bus.frame_done  = flags_reg.frame_done;
  assign bus.err         = err_reg;
  assign bus.wr_en       = wr_en_reg;
  assign bus.wr_addr     = wr_addr_reg;
  assign bus.wr_data     = wr_data_reg;

endmodule

// File: doc/pool_ctrl.md
POOL_CTRL -- requirements
Module: pool_ctrl

Interface
REQ-001 SHALL have parameter N, default 3, meaning the pooled output is N x N and the input tile is 2N x 2N.
REQ-002 SHALL have parameter DW, default 16, meaning the sample and result width.
REQ-003 SHALL have parameter TMO, default 16, meaning the cycles allowed for pool_done after the last write.
REQ-004 SHALL have port clk, input, 1, system clock, rising-edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, single-cycle frame request, honoured only in IDLE.
REQ-007 SHALL have port abort, input, 1, synchronous frame cancel.
REQ-008 SHALL have port in_valid, input, 1, convolution sample valid.
REQ-009 SHALL have port in_data, input, DW, convolution sample.
REQ-010 SHALL have port in_ready, output, 1, controller accepts a sample.
REQ-011 SHALL have port pool_en_reg, output, 1, load strobe to the pooling datapath.
REQ-012 SHALL have port pool_din, output, DW, sample forwarded to the pooling datapath.
REQ-013 SHALL have port pool_en, output, 1, pooling enable.
REQ-014 SHALL have port pool_out, input, DW, pooled value.
REQ-015 SHALL have port pool_addr, input, 16, pooled result index.
REQ-016 SHALL have port pool_done, input, 1, pooling complete.
REQ-017 SHALL have port pool_rst_n, output, 1, active-low clear to the pooling datapath.
REQ-018 SHALL have port wr_en, output, 1, result buffer write strobe.
REQ-019 SHALL have port wr_addr, output, 16, result buffer address.
REQ-020 SHALL have port wr_data, output, DW, result buffer data.
REQ-021 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-022 SHALL have port frame_done, output, 1, single-cycle frame completion pulse.
REQ-023 SHALL have port err, output, 1, sticky timeout flag.

Function
REQ-024 SHALL implement FSM states IDLE, LOAD, POOL, WAIT, CLEAR and DONE.
REQ-025 SHALL transition IDLE->LOAD when start=1; start received in any other state SHALL be ignored.
REQ-026 SHALL, in LOAD, drive in_ready=1 and pool_en_reg=in_valid; pool_din SHALL equal in_data combinationally.
REQ-027 SHALL count accepted samples (in_valid & in_ready); on the 4N*N-th sample the FSM SHALL go LOAD->POOL in the next cycle, and in_ready SHALL be 0 from that cycle.
REQ-028 SHALL, in POOL, hold pool_en=1 and, every cycle, register wr_en=1, wr_addr=pool_addr and wr_data=pool_out, giving 1-cycle write latency.
REQ-029 SHALL issue exactly N*N writes per frame; after the N*N-th write the FSM SHALL go POOL->WAIT.
REQ-030 SHALL, in WAIT, keep pool_en=1 with wr_en=0; on pool_done=1 it SHALL go to CLEAR.
REQ-031 SHALL, if pool_done is not seen within TMO cycles of entering WAIT, set err=1 and go to CLEAR.
REQ-032 SHALL, in CLEAR, drive pool_rst_n=0 for exactly one cycle, and pool_en=0, then go to DONE.
REQ-033 SHALL, in DONE, pulse frame_done=1 for one cycle, then go to IDLE.
REQ-034 SHALL, on abort=1 in LOAD, POOL or WAIT, go to CLEAR next cycle, suppress any further write, and skip frame_done (CLEAR->IDLE).
REQ-035 SHALL give abort priority over sample acceptance and pool_done in the same cycle.
REQ-036 SHALL clear the sample and write counters on entry to LOAD; the counters SHALL NOT wrap within a frame.
REQ-037 SHALL clear err only on reset.

Reset
REQ-038 SHALL, while reset_n=0, hold state=IDLE, counters=0, in_ready=0, pool_en_reg=0, pool_en=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, err=0 and pool_rst_n=0.
REQ-039 SHALL release pool_rst_n to 1 on the first clock after reset_n deasserts.
REQ-040 SHALL, when reset is asserted mid-frame, abandon the frame immediately with no write or frame_done after reset deassertion.

Verification
REQ-041 SHALL verify, with N=3, start then 36 back-to-back samples followed by pool_done -> 36 pool_en_reg pulses, 9 writes at wr_addr 0..8, one pool_rst_n low cycle, and frame_done one cycle after CLEAR.
REQ-042 SHALL verify that in_valid toggling every other cycle during LOAD -> exactly 36 samples accepted and POOL entered only after the 36th.
REQ-043 SHALL verify that pool_done withheld for 16 cycles in WAIT -> err=1, CLEAR entered, and err still 1 after the next frame.
REQ-044 SHALL verify that abort after 10 samples -> CLEAR next cycle, no writes, no frame_done, and IDLE after one cycle.
REQ-045 SHALL verify that start asserted while busy=1 -> ignored, with the frame completing normally.
REQ-046 SHALL verify that reset_n pulsed low during POOL -> all outputs at reset values and no write afterwards.
